// File: rtl/mem_interface_pkg.sv
// Shared definitions for the memory interface: FSM encoding, default sizes
// and the width of the request timeout counter.
package mem_interface_pkg;

  localparam int DATA_W_DEF  = 32;
  localparam int ADDR_W_DEF  = 9;
  localparam int TIMEOUT_DEF = 15;
  localparam int CNT_W       = 8;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RD_WAIT = 2'd1,
    S_WR_WAIT = 2'd2,
    S_DONE    = 2'd3
  } state_e;

endpackage

// File: rtl/mem_interface_md_register.sv
// Memory data register: DATA_W bits, loads either the bus value or the RAM
// read data, cleared synchronously by an active-low clear.
module md_register #(
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              clear,
  input  logic              load,
  input  logic              sel_rdata,
  input  logic [DATA_W-1:0] bus_in,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] q
);

  logic [DATA_W-1:0] data_d, data_q;

  // Next value: hold unless loading, then pick bus or RAM data.
  always_comb begin
    // NOTE: hold value assigned first so every path drives data_d; no latch.
    data_d = data_q;
    if (load) data_d = sel_rdata ? mem_rdata : bus_in;
  end

  // Register with synchronous active-low clear.
  always_ff @(posedge clock) begin
    // NOTE: non-blocking so every flop samples pre-edge values, whatever the order.
    if (!clear) data_q <= '0;
    else        data_q <= data_d;
  end

  assign q = data_q;

endmodule

// File: rtl/mem_interface.sv
// Memory-side neighbour of the datapath bus: holds MAR and MDR and runs a
// level req / pulse ack handshake to a word-addressed RAM, with a timeout.
module mem_interface
  import mem_interface_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clock,
  input  logic              clear,
  input  logic [DATA_W-1:0] bus_in,
  input  logic              MARin,
  input  logic              MDRin,
  input  logic              Read,
  input  logic              Write,
  output logic [DATA_W-1:0] mdr_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_rd_req,
  output logic              mem_wr_req,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              busy,
  output logic              done,
  output logic              error
);

  // Last counter value at which an unacknowledged request gives up.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_e            state_d, state_q;
  logic [CNT_W-1:0]  cnt_d, cnt_q;
  logic [ADDR_W-1:0] mar_d, mar_q;
  logic              err_d, err_q;
  logic              mdr_load, mdr_sel_rdata;
  logic [DATA_W-1:0] mdr_q;

  md_register #(.DATA_W(DATA_W)) u_mdr (
    .clock     (clock),
    .clear     (clear),
    .load      (mdr_load),
    .sel_rdata (mdr_sel_rdata),
    .bus_in    (bus_in),
    .mem_rdata (mem_rdata),
    .q         (mdr_q)
  );

  // Next-state, register loads and timeout; commands only honoured in IDLE.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    mar_d         = mar_q;
    err_d         = 1'b0;
    mdr_load      = 1'b0;
    mdr_sel_rdata = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (MARin) mar_d = bus_in[ADDR_W-1:0];
        if (MDRin && !Read) mdr_load = 1'b1;
        if (Read && Write) begin
          err_d = 1'b1;
        end else if (Read) begin
          state_d = S_RD_WAIT;
          cnt_d   = '0;
        end else if (Write) begin
          state_d = S_WR_WAIT;
          cnt_d   = '0;
        end
      end
      S_RD_WAIT, S_WR_WAIT: begin
        if (mem_ack) begin
          state_d       = S_DONE;
          mdr_load      = (state_q == S_RD_WAIT);
          mdr_sel_rdata = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State, counter, MAR and error pulse registers.
  always_ff @(posedge clock) begin
    if (!clear) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      mar_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mar_q   <= mar_d;
      err_q   <= err_d;
    end
  end

  assign mdr_data   = mdr_q;
  assign mem_wdata  = mdr_q;
  assign mem_addr   = mar_q;
  assign mem_rd_req = (state_q == S_RD_WAIT);
  assign mem_wr_req = (state_q == S_WR_WAIT);
  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE);
  assign error      = err_q;

endmodule

// File: tb/tb_mem_interface.sv
// Directed bench for mem_interface: stimulus pushes expected completion
// events into a scoreboard; a negedge monitor pops and compares on done/error.
module tb_mem_interface;

  logic        clock = 1'b0;
  logic        clear = 1'b0;
  logic [31:0] bus_in = '0;
  logic        MARin = 1'b0, MDRin = 1'b0, Read = 1'b0, Write = 1'b0;
  logic [31:0] mdr_data, mem_wdata, mem_rdata = '0;
  logic [8:0]  mem_addr;
  logic        mem_rd_req, mem_wr_req, mem_ack = 1'b0;
  logic        busy, done, error;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic        is_err;
    logic [31:0] mdr;
    logic [8:0]  addr;
    int          reqs;
    logic        wr;
    logic [31:0] wdata;
  } exp_t;

  exp_t sb[$];

  mem_interface dut (
    .clock      (clock),
    .clear      (clear),
    .bus_in     (bus_in),
    .MARin      (MARin),
    .MDRin      (MDRin),
    .Read       (Read),
    .Write      (Write),
    .mdr_data   (mdr_data),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rd_req (mem_rd_req),
    .mem_wr_req (mem_wr_req),
    .mem_rdata  (mem_rdata),
    .mem_ack    (mem_ack),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic expect_ev(input logic is_err, input logic [31:0] mdr, input logic [8:0] addr,
                           input int reqs, input logic wr, input logic [31:0] wdata);
    exp_t e;
    e.is_err = is_err; e.mdr = mdr; e.addr = addr; e.reqs = reqs; e.wr = wr; e.wdata = wdata;
    sb.push_back(e);
  endtask

  // Advance one cycle; inputs set after this are sampled at the next edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Monitor: counts request cycles and checks each done/error against the scoreboard.
  int          req_cnt = 0;
  logic        seen_wr = 1'b0;
  logic [8:0]  seen_addr = '0;
  logic [31:0] seen_wdata = '0;

  always @(negedge clock) begin
    if (clear !== 1'b1) begin
      req_cnt = 0;
    end else begin
      check("req_exclusive", {63'd0, mem_rd_req & mem_wr_req}, 64'd0);
      if (mem_rd_req === 1'b1 || mem_wr_req === 1'b1) begin
        req_cnt++;
        seen_wr    = mem_wr_req;
        seen_addr  = mem_addr;
        seen_wdata = mem_wdata;
      end
      if (done === 1'b1 || error === 1'b1) begin
        if (sb.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL stray_event: got done=%0b error=%0b, expected no event (t=%0t)",
                   done, error, $time);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("ev_error", {63'd0, error}, {63'd0, e.is_err});
          check("ev_done", {63'd0, done}, {63'd0, !e.is_err});
          check("ev_mdr", {32'd0, mdr_data}, {32'd0, e.mdr});
          check("ev_addr", {55'd0, mem_addr}, {55'd0, e.addr});
          check("ev_req_cycles", 64'(req_cnt), 64'(e.reqs));
          if (e.reqs > 0) begin
            check("ev_req_kind", {63'd0, seen_wr}, {63'd0, e.wr});
            check("ev_req_addr", {55'd0, seen_addr}, {55'd0, e.addr});
            if (e.wr) check("ev_wdata", {32'd0, seen_wdata}, {32'd0, e.wdata});
          end
        end
        req_cnt = 0;
      end
    end
  end

  initial begin
    // Reset and register loads.
    clear = 1'b0;
    tick(); tick();
    check("rst_mdr", {32'd0, mdr_data}, 64'd0);
    check("rst_addr", {55'd0, mem_addr}, 64'd0);
    check("rst_wdata", {32'd0, mem_wdata}, 64'd0);
    check("rst_ctl", {58'd0, mem_rd_req, mem_wr_req, busy, done, error, 1'b0}, 64'd0);
    clear = 1'b1;

    bus_in = 32'h0000_01A5; MARin = 1'b1; tick(); MARin = 1'b0;
    check("mar_load", {55'd0, mem_addr}, 64'h1A5);
    bus_in = 32'hDEAD_BEEF; MDRin = 1'b1; tick(); MDRin = 1'b0;
    check("mdr_load", {32'd0, mdr_data}, 64'hDEADBEEF);
    check("mdr_wdata", {32'd0, mem_wdata}, 64'hDEADBEEF);

    // Read: ack in third request cycle.
    bus_in = 32'h0000_0010; MARin = 1'b1; tick(); MARin = 1'b0;
    expect_ev(1'b0, 32'h1234_5678, 9'h010, 3, 1'b0, 32'h0);
    Read = 1'b1; tick(); Read = 1'b0;
    check("rd_busy", {63'd0, busy}, 64'd1);
    check("rd_req", {63'd0, mem_rd_req}, 64'd1);
    tick(); tick();
    mem_ack = 1'b1; mem_rdata = 32'h1234_5678; tick(); mem_ack = 1'b0; mem_rdata = '0;
    check("rd_done", {63'd0, done}, 64'd1);
    tick();
    check("rd_idle", {63'd0, busy}, 64'd0);

    // Write: MDR=CAFEF00D, MAR=1FF, ack in first request cycle.
    bus_in = 32'hCAFE_F00D; MDRin = 1'b1; tick(); MDRin = 1'b0;
    bus_in = 32'h0000_01FF; MARin = 1'b1; tick(); MARin = 1'b0;
    expect_ev(1'b0, 32'hCAFE_F00D, 9'h1FF, 1, 1'b1, 32'hCAFE_F00D);
    Write = 1'b1; tick(); Write = 1'b0;
    mem_ack = 1'b1; tick(); mem_ack = 1'b0;
    tick();
    check("wr_mdr_kept", {32'd0, mdr_data}, 64'hCAFEF00D);

    // Timeout with no ack: 15 request cycles then error, MDR unchanged.
    expect_ev(1'b1, 32'hCAFE_F00D, 9'h1FF, 15, 1'b0, 32'h0);
    Read = 1'b1; tick(); Read = 1'b0;
    repeat (17) tick();
    check("to_idle", {63'd0, busy}, 64'd0);

    // Ack on the 15th request cycle wins.
    expect_ev(1'b0, 32'hA5A5_0F0F, 9'h1FF, 15, 1'b0, 32'h0);
    Read = 1'b1; tick(); Read = 1'b0;
    repeat (14) tick();
    mem_ack = 1'b1; mem_rdata = 32'hA5A5_0F0F; tick(); mem_ack = 1'b0; mem_rdata = '0;
    tick(); tick();

    // Illegal Read+Write: error pulse, no request.
    expect_ev(1'b1, 32'hA5A5_0F0F, 9'h1FF, 0, 1'b0, 32'h0);
    Read = 1'b1; Write = 1'b1; tick(); Read = 1'b0; Write = 1'b0;
    check("ill_no_req", {62'd0, mem_rd_req, mem_wr_req}, 64'd0);
    check("ill_not_busy", {63'd0, busy}, 64'd0);
    tick();

    // Loads while busy are ignored.
    expect_ev(1'b0, 32'h0BAD_F00D, 9'h1FF, 2, 1'b0, 32'h0);
    Read = 1'b1; tick(); Read = 1'b0;
    bus_in = 32'hFFFF_FFFF; MDRin = 1'b1; MARin = 1'b1; tick(); MDRin = 1'b0; MARin = 1'b0;
    mem_ack = 1'b1; mem_rdata = 32'h0BAD_F00D; tick(); mem_ack = 1'b0; mem_rdata = '0;
    tick(); tick();
    check("busy_mar_kept", {55'd0, mem_addr}, 64'h1FF);
    check("busy_mdr_ram", {32'd0, mdr_data}, 64'h0BADF00D);

    // Reset during WR_WAIT; late ack must not produce done.
    Write = 1'b1; tick(); Write = 1'b0;
    tick();
    clear = 1'b0; tick(); clear = 1'b1;
    check("mid_rst_wr_req", {63'd0, mem_wr_req}, 64'd0);
    check("mid_rst_mdr", {32'd0, mdr_data}, 64'd0);
    check("mid_rst_addr", {55'd0, mem_addr}, 64'd0);
    mem_ack = 1'b1; tick(); mem_ack = 1'b0;
    check("late_ack_no_done", {62'd0, done, busy}, 64'd0);
    tick(); tick();

    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_interface.md
Name: mem_interface

Overview:
- Memory-side neighbour of the datapath bus. Holds the MAR and the MDR.
- MAR and MDR load from the bus output; MDR contents feed the bus MDR input.
- Runs a req/ack handshake FSM to an external word-addressed RAM for Read and Write microsteps.
- Sits directly downstream of the bus (consumes its output) and upstream of it (produces its MDR input).

Parameters:
- DATA_W, 32, data word width (bus width)
- ADDR_W, 9, RAM address width; MAR holds the low ADDR_W bits of the bus
- TIMEOUT, 15, max cycles a request waits for mem_ack before abort (1..255)

Ports:
- clock  in  1  single system clock, rising edge
- clear  in  1  synchronous, active-low reset
- bus_in  in  DATA_W  bus output value
- MARin  in  1  load MAR from bus_in
- MDRin  in  1  load MDR (source selected by Read, see Behaviour)
- Read  in  1  start a RAM read into MDR
- Write  in  1  start a RAM write of MDR
- mdr_data  out  DATA_W  current MDR, drives the bus MDR input
- mem_addr  out  ADDR_W  current MAR
- mem_wdata  out  DATA_W  current MDR
- mem_rd_req  out  1  read request, level, held until ack/abort
- mem_wr_req  out  1  write request, level, held until ack/abort
- mem_rdata  in  DATA_W  RAM read data, valid with mem_ack
- mem_ack  in  1  RAM completion, one-cycle pulse
- busy  out  1  high whenever FSM not IDLE
- done  out  1  one-cycle pulse on successful completion
- error  out  1  one-cycle pulse on abort or illegal command

Behaviour:
- Reset (clear=0 at an edge):
  - MAR=0, MDR=0, state=IDLE, counter=0.
  - All outputs 0; mdr_data, mem_addr and mem_wdata read 0.
  - Applies mid-transaction: requests drop the next cycle; a late mem_ack is ignored.
- FSM states: IDLE, RD_WAIT, WR_WAIT, DONE.
- IDLE:
  - MARin=1 -> MAR <= bus_in[ADDR_W-1:0].
  - MDRin=1 and Read=0 -> MDR <= bus_in.
  - Read=1 and Write=0 -> RD_WAIT, counter <= 0.
  - Write=1 and Read=0 -> WR_WAIT, counter <= 0.
  - Read=1 and Write=1 -> stay IDLE, error pulse next cycle, no request, MDR/MAR unchanged except by MARin.
  - MARin in the same cycle as Read/Write takes effect first: the request uses the new MAR.
- RD_WAIT:
  - mem_rd_req=1, mem_addr=MAR.
  - On mem_ack: MDR <= mem_rdata, -> DONE.
- WR_WAIT:
  - mem_wr_req=1, mem_addr=MAR, mem_wdata=MDR.
  - On mem_ack -> DONE.
- Timeout (RD_WAIT/WR_WAIT):
  - Counter increments each cycle without ack.
  - Counter==TIMEOUT-1 with no ack -> IDLE, error pulse, request dropped, MDR unchanged.
  - Ack in that same cycle wins (success).
- DONE: done=1 for exactly one cycle, -> IDLE.
- Latency: command sampled at edge 0; request visible cycle 1. Ack sampled at edge k (k>=1) -> MDR updated and done=1 in cycle k+1. Next command accepted in cycle k+2.
- Busy: while busy=1, MARin/MDRin/Read/Write are ignored (no load, no queueing).
- Stray ack: mem_ack in IDLE or DONE is ignored.
- mem_rd_req and mem_wr_req are never both 1.
- Outputs mem_addr, mem_wdata and mdr_data are registered-only (no combinational path from inputs).

Decomposition:
- Shared package: state encoding for IDLE/RD_WAIT/WR_WAIT/DONE; DATA_W/ADDR_W/TIMEOUT defaults; counter width constant (8).
- One natural sub-module: md_register, a DATA_W register with 2:1 input mux (bus_in vs mem_rdata), load enable, and synchronous active-low clear.
- MAR, FSM and timeout counter live in mem_interface.

Test Plan:
- Reset/load: clear=0 for 2 cycles -> all outputs 0. bus_in=0x0000_01A5, MARin=1 -> mem_addr=0x1A5. bus_in=0xDEAD_BEEF, MDRin=1 -> mdr_data=0xDEADBEEF next cycle.
- Read: MAR=0x010, Read pulse, RAM acks in the 3rd request cycle with 0x1234_5678 -> mem_rd_req high 3 cycles, mdr_data=0x12345678 and done=1 the cycle after ack, busy low after.
- Write: MDR=0xCAFE_F00D, MAR=0x1FF, Write pulse, ack after 1 cycle -> mem_wr_req with mem_addr=0x1FF and mem_wdata=0xCAFEF00D, done pulse, MDR unchanged.
- Timeout: Read with no ack, TIMEOUT=15 -> mem_rd_req high exactly 15 cycles, error pulse, MDR unchanged. Ack on the 15th cycle instead -> done, no error.
- Illegal and busy: Read=Write=1 -> error pulse, no request. During RD_WAIT, MDRin with bus_in=0xFFFF_FFFF and MARin -> ignored; result equals RAM data.
- Reset mid-op: clear=0 during WR_WAIT -> mem_wr_req=0 next cycle. A subsequent mem_ack produces no done.
